// File: rtl/lx32_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : lx32_imm_decode_stage
// Purpose  : RV32I immediate/format decode stage with a 2-entry skid buffer.
//            The instruction is decoded as it is accepted, and the decoded
//            result is stored in a two-deep FIFO. Decode latency is one cycle.
//            in_ready is a flop, so there is no combinational path from
//            out_ready to in_ready.
// Ports    : clk, rst (sync, active-high), flush (drops all held entries)
//            upstream   : in_valid, in_ready, in_instr[31:0], in_pc
//            downstream : out_valid, out_ready, out_instr, out_pc,
//                         out_imm[XLEN-1:0], out_fmt[2:0] (R0 I1 S2 B3 U4 J5 Z6),
//                         out_rd, out_rs1, out_rs2, out_illegal
// Config   : LX32_DECODE_CSR_IMM_EN  - when defined, SYSTEM with funct3[2]=1
//            decodes as format Z with a zero-extended rs1 field as immediate.
//            When it is undefined, that encoding is flagged illegal.
// Revision : 1.0 - initial release
// ============================================================================
module lx32_imm_decode_stage #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = XLEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [XLEN-1:0]     out_imm,
    output logic [2:0]          out_fmt,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic                out_illegal
);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

    localparam logic [2:0] c_FMT_R = 3'd0;
    localparam logic [2:0] c_FMT_I = 3'd1;
    localparam logic [2:0] c_FMT_S = 3'd2;
    localparam logic [2:0] c_FMT_B = 3'd3;
    localparam logic [2:0] c_FMT_U = 3'd4;
    localparam logic [2:0] c_FMT_J = 3'd5;
`ifdef LX32_DECODE_CSR_IMM_EN
    localparam logic [2:0] c_FMT_Z = 3'd6;
`endif

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;

    // ------------------------------------------------------------------
    // Decode of the incoming instruction. The immediate is built at
    // 32 bits and then sign-extended once to XLEN. This also gives U the
    // bit-31 sign extension for XLEN=64. The Z immediate has bit 31 clear,
    // so it stays zero-extended.
    // ------------------------------------------------------------------
    logic [31:0]     w_imm32;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;

    always_comb begin
        w_imm32   = 32'd0;
        w_fmt     = c_FMT_R;
        w_illegal = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (in_instr[6:0])
                c_OP_LUI, c_OP_AUIPC: begin
                    w_fmt   = c_FMT_U;
                    w_imm32 = {in_instr[31:12], 12'd0};
                end
                c_OP_JAL: begin
                    w_fmt   = c_FMT_J;
                    w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                               in_instr[30:21], 1'b0};
                end
                c_OP_JALR, c_OP_LOAD, c_OP_OPIMM, c_OP_FENCE: begin
                    w_fmt   = c_FMT_I;
                    w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end
                c_OP_SYSTEM: begin
                    if (in_instr[14]) begin
`ifdef LX32_DECODE_CSR_IMM_EN
                        w_fmt   = c_FMT_Z;
                        w_imm32 = {27'd0, in_instr[19:15]};
`else
                        w_illegal = 1'b1;
`endif
                    end else begin
                        w_fmt   = c_FMT_I;
                        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                    end
                end
                c_OP_STORE: begin
                    w_fmt   = c_FMT_S;
                    w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                end
                c_OP_BRANCH: begin
                    w_fmt   = c_FMT_B;
                    w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                               in_instr[11:8], 1'b0};
                end
                c_OP_OP: begin
                    w_fmt = c_FMT_R;
                end
                default: begin
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    assign w_imm = XLEN'($signed(w_imm32));

    // ------------------------------------------------------------------
    // Skid FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_in_ready;
    logic       w_accept;
    logic       w_drain;
    logic       w_load0;
    logic       w_load1;
    logic       w_shift;

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = out_valid & out_ready;

    // in_ready is registered from the next state, which keeps out_ready
    // off any combinational path to the upstream port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != c_ST_TWO);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: if (w_accept)             w_state_nxt = c_ST_ONE;
                c_ST_ONE: begin
                    if (w_accept && !w_drain)         w_state_nxt = c_ST_TWO;
                    else if (!w_accept && w_drain)    w_state_nxt = c_ST_EMPTY;
                end
                c_ST_TWO:   if (w_drain)              w_state_nxt = c_ST_ONE;
                default:                              w_state_nxt = c_ST_EMPTY;
            endcase
        end
    end

    // Slot 0 is always the head. A new entry goes to slot 0 when the
    // buffer is empty or the head leaves in the same cycle. Otherwise it
    // goes behind the head. Draining from TWO moves slot 1 forward.
    always_comb begin
        out_valid = (r_state != c_ST_EMPTY);
        in_ready  = r_in_ready;
        w_load0   = w_accept & ((r_state == c_ST_EMPTY) | ((r_state == c_ST_ONE) & w_drain));
        w_load1   = w_accept & (r_state == c_ST_ONE) & ~w_drain;
        w_shift   = w_drain & (r_state == c_ST_TWO);
    end

    // ------------------------------------------------------------------
    // Entry storage (no reset: contents are meaningless while invalid)
    // ------------------------------------------------------------------
    logic [31:0]         r_instr [2];
    logic [PC_WIDTH-1:0] r_pc    [2];
    logic [XLEN-1:0]     r_imm   [2];
    logic [2:0]          r_fmt   [2];
    logic                r_ill   [2];

    always_ff @(posedge clk) begin
        if (w_load0) begin
            r_instr[0] <= in_instr;
            r_pc[0]    <= in_pc;
            r_imm[0]   <= w_imm;
            r_fmt[0]   <= w_fmt;
            r_ill[0]   <= w_illegal;
        end else if (w_shift) begin
            r_instr[0] <= r_instr[1];
            r_pc[0]    <= r_pc[1];
            r_imm[0]   <= r_imm[1];
            r_fmt[0]   <= r_fmt[1];
            r_ill[0]   <= r_ill[1];
        end
        if (w_load1) begin
            r_instr[1] <= in_instr;
            r_pc[1]    <= in_pc;
            r_imm[1]   <= w_imm;
            r_fmt[1]   <= w_fmt;
            r_ill[1]   <= w_illegal;
        end
    end

    assign out_instr   = r_instr[0];
    assign out_pc      = r_pc[0];
    assign out_imm     = r_imm[0];
    assign out_fmt     = r_fmt[0];
    assign out_illegal = r_ill[0];
    assign out_rd      = r_instr[0][11:7];
    assign out_rs1     = r_instr[0][19:15];
    assign out_rs2     = r_instr[0][24:20];

endmodule
`default_nettype wire

// File: tb/tb_lx32_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_lx32_imm_decode_stage
// Purpose  : Bench for lx32_imm_decode_stage. It instantiates the design at
//            XLEN=32 and at XLEN=64, with both instances driven by the same
//            stimulus. A queue model with a reference decoder follows the
//            expected FIFO contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lx32_imm_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc64;
    logic [31:0] in_pc32;
    assign in_pc32 = in_pc64[31:0];

    logic        rdy_a, vld_a, ill_a;
    logic [31:0] instr_a, pc_a, imm_a;
    logic [2:0]  fmt_a;
    logic [4:0]  rd_a, rs1_a, rs2_a;

    logic        rdy_b, vld_b, ill_b;
    logic [31:0] instr_b;
    logic [63:0] pc_b, imm_b;
    logic [2:0]  fmt_b;
    logic [4:0]  rd_b, rs1_b, rs2_b;

    lx32_imm_decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_a), .in_instr(in_instr), .in_pc(in_pc32),
        .out_valid(vld_a), .out_ready(out_ready), .out_instr(instr_a), .out_pc(pc_a),
        .out_imm(imm_a), .out_fmt(fmt_a), .out_rd(rd_a), .out_rs1(rs1_a),
        .out_rs2(rs2_a), .out_illegal(ill_a)
    );

    lx32_imm_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_b), .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(vld_b), .out_ready(out_ready), .out_instr(instr_b), .out_pc(pc_b),
        .out_imm(imm_b), .out_fmt(fmt_b), .out_rd(rd_b), .out_rs1(rs1_b),
        .out_rs2(rs2_b), .out_illegal(ill_b)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference decoder. Immediates are built arithmetically from a
    // sign-extended copy of the word.
    function automatic void ref_decode(input logic [31:0] ins, output logic [63:0] imm,
                                       output logic [2:0] fmt, output logic ill);
        longint     s;
        logic [6:0] op;
        s   = longint'($signed(ins));
        op  = ins[6:0];
        imm = 64'd0;
        fmt = 3'd0;
        ill = 1'b0;
        if (ins[1:0] != 2'b11) begin
            ill = 1'b1;
        end else if (op == 7'h37 || op == 7'h17) begin
            fmt = 3'd4;
            imm = (s >>> 12) <<< 12;
        end else if (op == 7'h6F) begin
            fmt = 3'd5;
            imm = ((s >>> 31) << 20) | (longint'(ins[19:12]) << 12)
                | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
        end else if (op == 7'h67 || op == 7'h03 || op == 7'h13 || op == 7'h0F
                     || (op == 7'h73 && !ins[14])) begin
            fmt = 3'd1;
            imm = s >>> 20;
        end else if (op == 7'h73) begin
`ifdef LX32_DECODE_CSR_IMM_EN
            fmt = 3'd6;
            imm = longint'(ins[19:15]);
`else
            ill = 1'b1;
`endif
        end else if (op == 7'h23) begin
            fmt = 3'd2;
            imm = ((s >>> 25) << 5) | longint'(ins[11:7]);
        end else if (op == 7'h63) begin
            fmt = 3'd3;
            imm = ((s >>> 31) << 12) | (longint'(ins[7]) << 11)
                | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
        end else if (op == 7'h33) begin
            fmt = 3'd0;
        end else begin
            ill = 1'b1;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle. It starts at a negedge with the inputs already set.
    // It checks the outputs against the model, then advances the model
    // across the rising edge.
    task automatic cycle(output logic acc);
        logic        drn;
        logic [63:0] eimm;
        logic [2:0]  efmt;
        logic        eill;
        ent_t        e;
        chk("valid32", 64'(vld_a), 64'(q.size() > 0));
        chk("valid64", 64'(vld_b), 64'(q.size() > 0));
        chk("ready32", 64'(rdy_a), 64'(q.size() < 2));
        chk("ready64", 64'(rdy_b), 64'(q.size() < 2));
        if (q.size() > 0) begin
            e = q[0];
            ref_decode(e.instr, eimm, efmt, eill);
            chk("instr32", 64'(instr_a), 64'(e.instr));
            chk("pc32",    64'(pc_a),    64'(e.pc[31:0]));
            chk("imm32",   64'(imm_a),   64'(eimm[31:0]));
            chk("fmt32",   64'(fmt_a),   64'(efmt));
            chk("ill32",   64'(ill_a),   64'(eill));
            chk("rd32",    64'(rd_a),    64'(e.instr[11:7]));
            chk("rs1_32",  64'(rs1_a),   64'(e.instr[19:15]));
            chk("rs2_32",  64'(rs2_a),   64'(e.instr[24:20]));
            chk("instr64", 64'(instr_b), 64'(e.instr));
            chk("pc64",    pc_b,         e.pc);
            chk("imm64",   imm_b,        eimm);
            chk("fmt64",   64'(fmt_b),   64'(efmt));
            chk("ill64",   64'(ill_b),   64'(eill));
            chk("rd64",    64'(rd_b),    64'(e.instr[11:7]));
        end
        acc = in_valid && (q.size() < 2);
        drn = out_ready && (q.size() > 0);
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
            acc = 1'b0;
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back('{instr: in_instr, pc: in_pc64});
        end
        @(negedge clk);
    endtask

    // Offer one instruction into an empty stage with the output stalled.
    task automatic send(input logic [31:0] ins);
        logic a;
        in_valid  = 1'b1;
        in_instr  = ins;
        in_pc64   = {$urandom, $urandom};
        out_ready = 1'b0;
        cycle(a);
        in_valid  = 1'b0;
    endtask

    task automatic drain_one();
        logic a;
        out_ready = 1'b1;
        cycle(a);
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h33};
        w   = $urandom;
        if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
        return w;
    endfunction

    logic [31:0] lst [3];
    logic [31:0] em[$];
    int          idx;
    logic        acc;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc64 = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(acc);

        // addi x1,x0,-1
        send(32'hFFF00093);
        chk("addi_imm", 64'(imm_a), 64'hFFFFFFFF);
        chk("addi_fmt", 64'(fmt_a), 64'd1);
        chk("addi_rd",  64'(rd_a),  64'd1);
        chk("addi_ill", 64'(ill_a), 64'd0);
        drain_one();

        send(32'hFE000EE3);
        chk("beq_imm", 64'(imm_a), 64'hFFFFFFFC);
        chk("beq_fmt", 64'(fmt_a), 64'd3);
        drain_one();

        send(32'h0010006F);
        chk("jal_imm", 64'(imm_a), 64'h00000800);
        chk("jal_fmt", 64'(fmt_a), 64'd5);
        drain_one();

        send(32'h123452B7);
        chk("lui_imm64", imm_b, 64'h0000000012345000);
        drain_one();

        send(32'h800002B7);
        chk("luineg_imm64", imm_b, 64'hFFFFFFFF80000000);
        drain_one();

        send(32'h3002D073);
`ifdef LX32_DECODE_CSR_IMM_EN
        chk("csrrwi_fmt", 64'(fmt_a), 64'd6);
        chk("csrrwi_imm", 64'(imm_a), 64'd5);
        chk("csrrwi_ill", 64'(ill_a), 64'd0);
`else
        chk("csrrwi_fmt", 64'(fmt_a), 64'd0);
        chk("csrrwi_imm", 64'(imm_a), 64'd0);
        chk("csrrwi_ill", 64'(ill_a), 64'd1);
`endif
        drain_one();

        // Three instructions offered with the output stalled for 4 cycles.
        lst = '{32'h00100113, 32'h00208193, 32'h00318213};
        idx = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = lst[idx];
            in_pc64  = 64'(idx) * 4;
            cycle(acc);
            if (acc) idx++;
        end
        chk("skid_in_ready", 64'(rdy_a), 64'd0);
        chk("skid_head", 64'(instr_a), 64'(lst[0]));
        out_ready = 1'b1;
        em.delete();
        for (int i = 0; i < 10; i++) begin
            in_valid = (idx < 3);
            in_instr = lst[idx < 3 ? idx : 2];
            in_pc64  = 64'(idx) * 4;
            if (vld_a) em.push_back(instr_a);
            cycle(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("skid_count", 64'(em.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < em.size()) chk("skid_order", 64'(em[i]), 64'(lst[i]));
        end

        // Flush in TWO with an instruction being offered.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_instr = lst[i];
            cycle(acc);
        end
        chk("flush_pre_two", 64'(rdy_a), 64'd0);
        in_valid = 1'b1;
        in_instr = 32'h00A00513;
        flush    = 1'b1;
        cycle(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(vld_a), 64'd0);
        chk("flush_ready", 64'(rdy_a), 64'd1);
        out_ready = 1'b1;
        em.delete();
        for (int i = 0; i < 3; i++) begin
            if (vld_a) em.push_back(instr_a);
            cycle(acc);
        end
        chk("flush_no_emit", 64'(em.size()), 64'd0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc64   = {$urandom, $urandom};
            cycle(acc);
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
